// File: rtl/lms_pkg.sv
// rtl/lms_pkg.sv - shared types, constants and saturation helper for the LMS FIR filter
package lms_pkg;

  // Default sample/coefficient width, signed Q1.(DATA_W-1)
  localparam int DATA_W_DEF = 24;

  // Working width for width-reduction arithmetic; wide enough for any legal accumulator
  localparam int WIDE_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    FILTER,
    ERROR,
    UPDATE
  } state_t;

  // Fractional bits of a Q1.(w-1) value
  function automatic int frac_bits(input int w);
    return w - 1;
  endfunction

  // Clamp a wide signed value into the signed range of a w-bit number
  function automatic logic signed [WIDE_W-1:0] lms_sat(input logic signed [WIDE_W-1:0] v,
                                                        input int w);
    logic signed [WIDE_W-1:0] one;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    one = {{(WIDE_W-1){1'b0}}, 1'b1};
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/lms_mac.sv
// rtl/lms_mac.sv - signed multiplier with clearable accumulator, shared by filter and update phases
module lms_mac
  import lms_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = 2 * DATA_W_DEF + 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W-1:0] prod,
  output logic signed [ACC_W-1:0]    acc
);

  // Full-precision product; operands sign-extended first so no bits are lost
  assign prod = (2 * DATA_W)'(a) * (2 * DATA_W)'(b);

  // Accumulator: clear has priority so a new sample always starts from zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/lms_fir_filter.sv
// rtl/lms_fir_filter.sv - sequential LMS adaptive FIR; LMS_SATURATE_EN selects clamping over wrap-around
module lms_fir_filter
  import lms_pkg::*;
#(
  parameter int TAPS     = 8,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MU_SHIFT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] d_in,
  input  logic                     in_valid,
  input  logic                     adapt_en,
  output logic signed [DATA_W-1:0] y_out,
  output logic signed [DATA_W-1:0] e_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int K_W    = $clog2(TAPS);
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  localparam int FRAC   = frac_bits(DATA_W);
  localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);

  // Narrow a wide signed result to DATA_W bits: clamp or wrap depending on build
  function automatic logic signed [DATA_W-1:0] reduce(input logic signed [WIDE_W-1:0] v);
    logic signed [WIDE_W-1:0] t;
`ifdef LMS_SATURATE_EN
    t = lms_sat(v, DATA_W);
`else
    t = v;
`endif
    return t[DATA_W-1:0];
  endfunction

  state_t                    state;
  logic [K_W-1:0]            k;
  logic signed [DATA_W-1:0]  x_dl [TAPS];
  logic signed [DATA_W-1:0]  w    [TAPS];
  logic signed [DATA_W-1:0]  d_reg;
  logic signed [DATA_W-1:0]  mac_a;
  logic signed [DATA_W-1:0]  mac_b;
  logic                      mac_clr;
  logic                      mac_en;
  logic                      accept;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  y_new;
  logic signed [DATA_W-1:0]  e_new;
  logic signed [DATA_W-1:0]  w_new;

  // Operand steering: weights during FILTER, registered error during UPDATE; x tap always
  always_comb begin
    accept  = in_valid && (state == IDLE);
    mac_clr = accept;
    mac_en  = (state == FILTER);
    mac_a   = (state == UPDATE) ? e_out : w[k];
    mac_b   = x_dl[k];
    y_new   = reduce(WIDE_W'(acc >>> FRAC));
    e_new   = reduce(WIDE_W'(d_reg) - WIDE_W'(y_new));
    w_new   = reduce(WIDE_W'(w[k]) + WIDE_W'(prod >>> (FRAC + MU_SHIFT)));
  end

  lms_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clr  (mac_clr),
    .en   (mac_en),
    .a    (mac_a),
    .b    (mac_b),
    .prod (prod),
    .acc  (acc)
  );

  // Control FSM with tap counter and registered status/result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      k         <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      y_out     <= '0;
      e_out     <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= FILTER;
            k     <= '0;
            busy  <= 1'b1;
          end
        end
        FILTER: begin
          if (k == K_LAST) begin
            state <= ERROR;
            k     <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        ERROR: begin
          y_out     <= y_new;
          e_out     <= e_new;
          out_valid <= 1'b1;
          k         <= '0;
          if (adapt_en) begin
            state <= UPDATE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        UPDATE: begin
          if (k == K_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            k     <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Delay line and desired-sample capture on accept; one weight written per UPDATE cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_reg <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_dl[i] <= '0;
        w[i]    <= '0;
      end
    end else begin
      if (accept) begin
        d_reg   <= d_in;
        x_dl[0] <= x_in;
        for (int i = 1; i < TAPS; i++) begin
          x_dl[i] <= x_dl[i-1];
        end
      end
      if (state == UPDATE) begin
        w[k] <= w_new;
      end
    end
  end

endmodule
